gpio_in_debounce: RTL and testbench

- Input-side companion to the board LED output: conditions one raw push-button/switch pin for the core.
- Stages: 2-flop synchronizer, 4-state debounce FSM, one-cycle edge pulses, sticky interrupt-pending flag with acknowledge handshake, wrapping press counter.
- Sits in the FPGA top between the board pin and the core's interrupt/peripheral logic.

---
 rtl/gpio_in_debounce.sv | 147 ++++++++++++++
 tb/tb_gpio_in_debounce.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// Conditions one raw push-button/switch pin for the core.
// The pin passes through a two-flop synchronizer and then a four-state
// debounce FSM. The block produces a debounced level, one-cycle
// rise/fall pulses, a sticky interrupt-pending flag cleared by an ack
// pulse, and a wrapping count of accepted presses.
module gpio_in_debounce #(
    parameter int unsigned DebounceCycles = 4,
    parameter int unsigned CntWidth       = 8,
    parameter bit          IrqOnFall      = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn,
    input  logic                ack,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic                irq_pending,
    output logic [CntWidth-1:0] presses
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    // Last count value before a change is accepted; cnt never goes past it.
    localparam logic [15:0] CntLast = 16'(DebounceCycles - 1);

    logic                sync0_q, sync0_d;
    logic                sync1_q, sync1_d;
    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                irq_q, irq_d;
    logic [CntWidth-1:0] presses_q, presses_d;
    logic                s;
    logic                irq_set;

    // The raw pin is touched only by the first synchronizer flop.
    assign s = sync1_q;

    // Next-state logic: synchronizer, debounce FSM, pulses, irq flag, counter.
    always_comb begin
        sync0_d   = btn;
        sync1_d   = sync0_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;

        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = 16'd1;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    // Glitch: drop back without touching any output.
                    state_d = STABLE_LO;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_HI;
                    cnt_d   = 16'd0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = 16'd1;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_LO;
                    cnt_d   = 16'd0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = 16'd0;
            end
        endcase

        // A new event beats a simultaneous ack so no request is lost.
        irq_set = rise_d | (IrqOnFall & fall_d);
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        presses_d = presses_q + CntWidth'(rise_d);
    end

    // State registers; synchronous reset discards any pending change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q   <= 1'b0;
            sync1_q   <= 1'b0;
            state_q   <= STABLE_LO;
            cnt_q     <= 16'd0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            irq_q     <= 1'b0;
            presses_q <= '0;
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            irq_q     <= irq_d;
            presses_q <= presses_d;
        end
    end

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign irq_pending = irq_q;
    assign presses     = presses_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Testbench for gpio_in_debounce: two instances share the pin and ack,
// one with IrqOnFall=0 and one with IrqOnFall=1. Expected edge events
// are queued when stimulus is applied and compared when the DUT pulses.
module tb_gpio_in_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic       ack;
    logic       level, rise, fall, irq_pending;
    logic [7:0] presses;
    logic       level_f, rise_f, fall_f, irq_f;
    logic [7:0] presses_f;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Bench-side model state.
    int   press_cnt = 0;
    logic irq_m     = 1'b0;
    logic irq_fm    = 1'b0;

    typedef struct {
        int         cyc;
        bit         is_rise;
        logic [7:0] presses;
        logic       irq;
        logic       irq_f;
    } exp_t;

    exp_t sbq[$];

    gpio_in_debounce #(
        .DebounceCycles(4),
        .CntWidth      (8),
        .IrqOnFall     (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .ack        (ack),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .irq_pending(irq_pending),
        .presses    (presses)
    );

    gpio_in_debounce #(
        .DebounceCycles(4),
        .CntWidth      (8),
        .IrqOnFall     (1'b1)
    ) dut_f (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .ack        (ack),
        .level      (level_f),
        .rise       (rise_f),
        .fall       (fall_f),
        .irq_pending(irq_f),
        .presses    (presses_f)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until rise or fall pulses on the main DUT, or the budget runs out.
    task automatic wait_event(input int budget, output int ev_cyc);
        ev_cyc = -1;
        for (int i = 0; i < budget && ev_cyc < 0; i++) begin
            tick();
            if (rise === 1'b1 || fall === 1'b1) ev_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn   = 1'b1;
        ack   = 1'b0;
        repeat (3) tick();
        checks++;
        if ({level, rise, fall, irq_pending, presses} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {level, rise, fall, irq_pending, presses});
        end
        checks++;
        if ({level_f, rise_f, fall_f, irq_f, presses_f} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs_f got=%b exp=0", {level_f, rise_f, fall_f, irq_f, presses_f});
        end
        btn   = 1'b0;
        reset = 1'b0;
        repeat (8) tick();
        checks++;
        if (level !== 1'b0) begin
            failures++;
            $display("FAIL reset_level_after got=%b exp=0", level);
        end
    endtask

    task automatic test_glitch();
        int ev;
        btn = 1'b1;
        repeat (3) tick();
        btn = 1'b0;
        wait_event(12, ev);
        checks++;
        if (ev !== -1) begin
            failures++;
            $display("FAIL glitch_no_event got_cyc=%0d exp=none", ev);
        end
        checks++;
        if (level !== 1'b0 || irq_pending !== 1'b0 || presses !== 8'd0 || irq_f !== 1'b0) begin
            failures++;
            $display("FAIL glitch_state level=%b irq=%b presses=%0d irq_f=%b exp=0,0,0,0",
                     level, irq_pending, presses, irq_f);
        end
    endtask

    task automatic test_clean_press();
        exp_t e;
        int   ev;
        btn       = 1'b1;
        press_cnt = press_cnt + 1;
        irq_m     = 1'b1;
        irq_fm    = 1'b1;
        e.cyc     = cyc + 6;
        e.is_rise = 1'b1;
        e.presses = 8'(press_cnt);
        e.irq     = irq_m;
        e.irq_f   = irq_fm;
        sbq.push_back(e);
        wait_event(20, ev);
        e = sbq.pop_front();
        checks++;
        if (ev !== e.cyc) begin
            failures++;
            $display("FAIL press_latency got_cyc=%0d exp_cyc=%0d", ev, e.cyc);
        end
        checks++;
        if (rise !== e.is_rise || fall !== 1'b0 || level !== 1'b1) begin
            failures++;
            $display("FAIL press_pulse rise=%b fall=%b level=%b exp=1,0,1", rise, fall, level);
        end
        checks++;
        if (presses !== e.presses || irq_pending !== e.irq || irq_f !== e.irq_f) begin
            failures++;
            $display("FAIL press_state presses=%0d irq=%b irq_f=%b exp=%0d,%b,%b",
                     presses, irq_pending, irq_f, e.presses, e.irq, e.irq_f);
        end
        tick();
        checks++;
        if (rise !== 1'b0 || level !== 1'b1 || irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL press_after rise=%b level=%b irq=%b exp=0,1,1", rise, level, irq_pending);
        end
    endtask

    task automatic test_ack();
        ack = 1'b1;
        tick();
        ack    = 1'b0;
        irq_m  = 1'b0;
        irq_fm = 1'b0;
        checks++;
        if (irq_pending !== irq_m || irq_f !== irq_fm) begin
            failures++;
            $display("FAIL ack_clear irq=%b irq_f=%b exp=%b,%b", irq_pending, irq_f, irq_m, irq_fm);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++;
        if (irq_pending !== 1'b0 || presses !== 8'(press_cnt) || level !== 1'b1) begin
            failures++;
            $display("FAIL ack_idle irq=%b presses=%0d level=%b exp=0,%0d,1",
                     irq_pending, presses, level, press_cnt);
        end
    endtask

    task automatic test_bouncy_release();
        exp_t e;
        int   ev;
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
        btn = 1'b1;
        tick();
        btn       = 1'b0;
        irq_fm    = 1'b1;
        e.cyc     = cyc + 6;
        e.is_rise = 1'b0;
        e.presses = 8'(press_cnt);
        e.irq     = irq_m;
        e.irq_f   = irq_fm;
        sbq.push_back(e);
        wait_event(20, ev);
        e = sbq.pop_front();
        checks++;
        if (ev !== e.cyc) begin
            failures++;
            $display("FAIL bounce_latency got_cyc=%0d exp_cyc=%0d", ev, e.cyc);
        end
        checks++;
        if (fall !== 1'b1 || rise !== e.is_rise || level !== 1'b0) begin
            failures++;
            $display("FAIL bounce_pulse fall=%b rise=%b level=%b exp=1,0,0", fall, rise, level);
        end
        checks++;
        if (irq_pending !== e.irq || irq_f !== e.irq_f || presses !== e.presses) begin
            failures++;
            $display("FAIL bounce_irq irq=%b irq_f=%b presses=%0d exp=%b,%b,%0d",
                     irq_pending, irq_f, presses, e.irq, e.irq_f, e.presses);
        end
        wait_event(15, ev);
        checks++;
        if (ev !== -1) begin
            failures++;
            $display("FAIL bounce_single_fall got_cyc=%0d exp=none", ev);
        end
        ack = 1'b1;
        tick();
        ack    = 1'b0;
        irq_fm = 1'b0;
    endtask

    task automatic test_ack_same_edge();
        exp_t e;
        int   ev;
        btn       = 1'b1;
        press_cnt = press_cnt + 1;
        irq_m     = 1'b1;
        irq_fm    = 1'b1;
        e.cyc     = cyc + 6;
        e.is_rise = 1'b1;
        e.presses = 8'(press_cnt);
        e.irq     = irq_m;
        e.irq_f   = irq_fm;
        sbq.push_back(e);
        repeat (5) tick();
        ack = 1'b1;
        wait_event(5, ev);
        ack = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (ev !== e.cyc || rise !== e.is_rise) begin
            failures++;
            $display("FAIL ackrise_latency got_cyc=%0d rise=%b exp_cyc=%0d", ev, rise, e.cyc);
        end
        checks++;
        if (irq_pending !== e.irq || irq_f !== e.irq_f || presses !== e.presses) begin
            failures++;
            $display("FAIL ackrise_set_wins irq=%b irq_f=%b presses=%0d exp=%b,%b,%0d",
                     irq_pending, irq_f, presses, e.irq, e.irq_f, e.presses);
        end
        tick();
        checks++;
        if (irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL ackrise_hold irq=%b exp=1", irq_pending);
        end
        btn    = 1'b0;
        e.cyc  = cyc + 6;
        e.is_rise = 1'b0;
        sbq.push_back(e);
        wait_event(20, ev);
        e = sbq.pop_front();
        checks++;
        if (ev !== e.cyc || fall !== 1'b1) begin
            failures++;
            $display("FAIL ackrise_release got_cyc=%0d fall=%b exp_cyc=%0d", ev, fall, e.cyc);
        end
        ack = 1'b1;
        tick();
        ack    = 1'b0;
        irq_m  = 1'b0;
        irq_fm = 1'b0;
    endtask

    task automatic test_counter_wrap();
        exp_t e;
        int   ev;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        press_cnt = 0;
        irq_m     = 1'b0;
        irq_fm    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            btn       = 1'b1;
            press_cnt = (press_cnt + 1) % 256;
            e.cyc     = cyc + 6;
            e.is_rise = 1'b1;
            e.presses = 8'(press_cnt);
            e.irq     = 1'b1;
            e.irq_f   = 1'b1;
            sbq.push_back(e);
            wait_event(20, ev);
            e = sbq.pop_front();
            checks++;
            if (ev !== e.cyc || rise !== 1'b1 || presses !== e.presses) begin
                failures++;
                $display("FAIL wrap_press%0d got_cyc=%0d presses=%0d exp_cyc=%0d presses=%0d",
                         i + 1, ev, presses, e.cyc, e.presses);
            end
            btn = 1'b0;
            wait_event(20, ev);
        end
        checks++;
        if (presses !== 8'd0 || irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL wrap_final presses=%0d irq=%b exp=0,1", presses, irq_pending);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   ev;
        btn = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        press_cnt = 1;
        checks++;
        if ({level, rise, fall, irq_pending, presses} !== 12'h000) begin
            failures++;
            $display("FAIL midreset_outputs got=%b exp=0", {level, rise, fall, irq_pending, presses});
        end
        e.cyc     = cyc + 6;
        e.is_rise = 1'b1;
        e.presses = 8'(press_cnt);
        e.irq     = 1'b1;
        e.irq_f   = 1'b1;
        sbq.push_back(e);
        wait_event(20, ev);
        e = sbq.pop_front();
        checks++;
        if (ev !== e.cyc || rise !== e.is_rise || level !== 1'b1) begin
            failures++;
            $display("FAIL midreset_latency got_cyc=%0d rise=%b level=%b exp_cyc=%0d",
                     ev, rise, level, e.cyc);
        end
        checks++;
        if (presses !== e.presses || irq_pending !== e.irq) begin
            failures++;
            $display("FAIL midreset_state presses=%0d irq=%b exp=%0d,%b",
                     presses, irq_pending, e.presses, e.irq);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_ack();
        test_bouncy_release();
        test_ack_same_edge();
        test_counter_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
